// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: signedness, divide-by-zero and
// the 0x80000000 / -1 overflow case are all resolved here.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    input  logic        is_div_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] prod_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Sign-extending to 64 bits makes the truncated product correct for both signed and unsigned.
    always_comb begin
        a_ext_s = signed_i ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
        b_ext_s = signed_i ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Magnitude divide; -0x80000000 wraps to itself so overflow yields LO=0x80000000, HI=0.
    always_comb begin
        a_neg_s       = signed_i & a_i[31];
        b_neg_s       = signed_i & b_i[31];
        a_mag_s       = a_neg_s ? (32'd0 - a_i) : a_i;
        b_mag_s       = b_neg_s ? (32'd0 - b_i) : b_i;
        div_by_zero_o = (b_i == 32'd0);
        b_safe_s      = div_by_zero_o ? 32'd1 : b_mag_s;
        q_mag_s       = a_mag_s / b_safe_s;
        r_mag_s       = a_mag_s % b_safe_s;
        q_s           = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        r_s           = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Select the datapath feeding HI/LO.
    always_comb begin
        if (is_div_i) begin
            result_o = {r_s, q_s};
        end else begin
            result_o = prod_s;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: latches operands on start, holds busy for a fixed latency,
// then commits the arithmetic result to HI/LO; mthi/mtlo write immediately.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q;
    logic [63:0]      arith_res_s;
    logic             div_by_zero_s;

    mdu_arith u_arith (
        .a_i           (a_q),
        .b_i           (b_q),
        .signed_i      (sgn_q),
        .is_div_i      (state_q == S_DIV),
        .result_o      (arith_res_s),
        .div_by_zero_o (div_by_zero_s)
    );

    // Next-state logic: launch from IDLE only; starts while busy are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op_e'(MDUop))
                        MDU_MULT, MDU_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            a_d     = srcA;
                            b_d     = srcB;
                            sgn_d   = (mdu_op_e'(MDUop) == MDU_MULT);
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            a_d     = srcA;
                            b_d     = srcB;
                            sgn_d   = (mdu_op_e'(MDUop) == MDU_DIV);
                        end
                        MDU_MTHI: hi_d = srcA;
                        MDU_MTLO: lo_d = srcA;
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_IDLE;
                    // A zero divisor burns the latency but leaves HI/LO untouched.
                    if (!((state_q == S_DIV) && div_by_zero_s)) begin
                        hi_d = arith_res_s[63:32];
                        lo_d = arith_res_s[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand latches and HI/LO registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the EX stage; the MIPS HI/LO resource alongside the single-cycle ALU.
- Latches operands on a one-cycle start pulse and holds busy for a fixed latency, emulating hardware timing.
- Commits results to the HI/LO registers at the end of the latency and services mthi/mtlo writes.
- The hazard unit stalls any MDU instruction while (start | busy).

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu.
- DIV_CYCLES, 10, cycles busy is held for div/divu.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that launches the op on MDUop
- MDUop  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op)
- srcA  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- srcB  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: every rising edge with reset=1 forces state IDLE, counter 0, busy 0, HI 0, LO 0, latched operands 0.
  - Reset has priority over all other inputs, including mid-operation; the in-flight result is discarded.
- States: IDLE, MUL, DIV. busy = (state != IDLE), registered.
- IDLE, start=1 at edge E0:
  - mult/multu: latch srcA, srcB and signedness; go to MUL; counter = MULT_CYCLES-1.
  - div/divu: same latching; go to DIV; counter = DIV_CYCLES-1.
  - mthi: HI <= srcA at E0; stay IDLE; busy stays 0. mtlo: same for LO.
  - none/reserved: no effect.
- MUL/DIV: counter decrements each edge. At the edge where counter==0:
  - commit the result to HI/LO;
  - return to IDLE.
- Timing: busy is high exactly N cycles (after E0 through E(N-1)). HI/LO update at edge EN and are readable the cycle busy falls.
- HI/LO hold their old values throughout the busy window.
- start while busy: ignored entirely, including mthi/mtlo. The upstream stall makes this illegal; the bench flags it as an assertion error.
- start and MDUop are sampled only when start=1. MDUop is a don't-care otherwise.
- mult: signed 32x32 -> 64-bit product; HI = bits 63:32, LO = bits 31:0. multu: unsigned, same split.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero (latched srcB==0): full DIV latency is still spent; HI/LO left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap.
- Arithmetic is computed from the latched operands only. Changes on srcA/srcB during busy have no effect.

Decomposition:
- Package mdu_pkg holds:
  - MDUop encodings (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO);
  - state encoding (S_IDLE, S_MUL, S_DIV);
  - default latency constants.
- Sub-module mdu_arith: purely combinational.
  - Inputs: latched operands, signed flag, mul/div select.
  - Outputs: 64-bit {hi,lo} result and a div_by_zero flag.
  - Owns all signed/unsigned and overflow rules.
- mdu_ctrl keeps only the FSM, counter, operand latches and the HI/LO registers.

Test Plan:
- mult srcA=0xFFFFFFFF srcB=0x00000002, start at E0 -> busy=1 for 5 cycles; at E5 HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Driving srcA=0 during busy does not change the result.
- div srcA=0xFFFFFFF9 (-7) srcB=2 -> busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu srcA=7 srcB=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Then mthi srcA=0xDEADBEEF -> HI=0xDEADBEEF on the next edge; busy never asserts.
- Start div, assert reset at cycle 4 -> next edge busy=0, HI=LO=0. A later mult 3*4 completes normally with LO=12, HI=0.
